// File: rtl/ram_dp_be.sv
// ram_dp_be: single-clock true dual-port RAM with per-byte write enables,
// selectable read-during-write behaviour, optional output register,
// read-valid strobes, A-over-B write collision and a hardware init sweep.
//
// Read data is taken from the array on the request edge (pre-write word).
// The post-write word for write-first readback is rebuilt one cycle later
// from that pre-write word plus the registered lane masks and write data of
// both ports, so the array itself only ever sees a plain registered read.
module ram_dp_be #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 256,
  parameter int               LG_DEPTH = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter int               RDW_MODE = 0,
  parameter int               OUT_REG  = 0,
  localparam int              NB       = WIDTH / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_req,
  output logic                busy,
  input  logic                ena,
  input  logic [NB-1:0]       wea,
  input  logic [LG_DEPTH-1:0] addra,
  input  logic [WIDTH-1:0]    dina,
  output logic [WIDTH-1:0]    douta,
  output logic                valida,
  input  logic                enb,
  input  logic [NB-1:0]       web,
  input  logic [LG_DEPTH-1:0] addrb,
  input  logic [WIDTH-1:0]    dinb,
  output logic [WIDTH-1:0]    doutb,
  output logic                validb
);

  localparam logic [LG_DEPTH:0]   DEPTH_W = (LG_DEPTH + 1)'(DEPTH);
  localparam logic [LG_DEPTH-1:0] LAST    = LG_DEPTH'(DEPTH - 1);

  // state   | meaning
  // ST_INIT | sweep writes INIT_VAL to word cnt, user ports blocked
  // ST_IDLE | normal dual-port operation
  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [LG_DEPTH-1:0]   cnt, cnt_nxt;

  logic [WIDTH-1:0]      mem [0:DEPTH-1];

  logic                  in_a, in_b, acc_a, acc_b, same_addr;
  logic [NB-1:0]         wr_a, wr_b;
  logic [WIDTH-1:0]      old_a, old_b;
  logic [WIDTH-1:0]      din_a_q, din_b_q;
  logic [NB-1:0]         own_a_q, oth_a_q, own_b_q, oth_b_q;
  logic [WIDTH-1:0]      merged_a, merged_b, rd_a, rd_b;
  logic                  v1_a, v1_b;

  // sweep FSM state and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // sweep FSM next state; init_req only honoured from idle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy      = (state == ST_INIT);
  assign in_a      = ({1'b0, addra} < DEPTH_W);
  assign in_b      = ({1'b0, addrb} < DEPTH_W);
  assign acc_a     = ena & ~busy;
  assign acc_b     = enb & ~busy;
  assign wr_a      = (acc_a && in_a) ? wea : '0;
  assign wr_b      = (acc_b && in_b) ? web : '0;
  assign same_addr = (addra == addrb);

  // array: sweep write or byte-lane user writes (A issued last so it wins
  // a shared lane), plus read-first registered reads for both ports
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= INIT_VAL;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
        if (wr_a[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
      end
    end
    if (acc_a) old_a <= in_a ? mem[addra] : '0;
    if (acc_b) old_b <= in_b ? mem[addrb] : '0;
  end

  // lane masks and write data needed to rebuild the post-write word
  always_ff @(posedge clk) begin
    din_a_q <= dina;
    din_b_q <= dinb;
    own_a_q <= wr_a;
    oth_a_q <= same_addr ? wr_b : '0;
    own_b_q <= wr_b;
    oth_b_q <= same_addr ? wr_a : '0;
  end

  // post-write word as seen by each port, A-over-B on shared lanes
  always_comb begin
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (own_a_q[i])      merged_a[8*i +: 8] = din_a_q[8*i +: 8];
      else if (oth_a_q[i]) merged_a[8*i +: 8] = din_b_q[8*i +: 8];
      if (oth_b_q[i])      merged_b[8*i +: 8] = din_a_q[8*i +: 8];
      else if (own_b_q[i]) merged_b[8*i +: 8] = din_b_q[8*i +: 8];
    end
  end

  // write-first only applies when the port itself wrote; pure reads see old data
  assign rd_a = ((RDW_MODE != 0) && (|own_a_q)) ? merged_a : old_a;
  assign rd_b = ((RDW_MODE != 0) && (|own_b_q)) ? merged_b : old_b;

  // first-stage read valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_a <= 1'b0;
      v1_b <= 1'b0;
    end else begin
      v1_a <= acc_a;
      v1_b <= acc_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] dq_a, dq_b;
      logic             vq_a, vq_b;

      // extra output register; data only loads when a result arrives
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dq_a <= '0;
          dq_b <= '0;
          vq_a <= 1'b0;
          vq_b <= 1'b0;
        end else begin
          vq_a <= v1_a;
          vq_b <= v1_b;
          if (v1_a) dq_a <= rd_a;
          if (v1_b) dq_b <= rd_b;
        end
      end

      assign douta  = dq_a;
      assign doutb  = dq_b;
      assign valida = vq_a;
      assign validb = vq_b;
    end else begin : g_noreg
      logic [WIDTH-1:0] hold_a, hold_b;

      // last delivered word, shown whenever no new result is due
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_a <= '0;
          hold_b <= '0;
        end else begin
          if (v1_a) hold_a <= rd_a;
          if (v1_b) hold_b <= rd_b;
        end
      end

      assign douta  = v1_a ? rd_a : hold_a;
      assign doutb  = v1_b ? rd_b : hold_b;
      assign valida = v1_a;
      assign validb = v1_b;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances share one stimulus stream.
//   u0: DEPTH=256, read-first, no output register
//   u1: DEPTH=200 (addresses 200..255 out of range), write-first, output register
// A word-level model checks busy/valid/dout of both every cycle; directed
// steps add literal expectations.
module tb_ram_dp_be;

  localparam int          DEP0 = 256;
  localparam int          DEP1 = 200;
  localparam logic [31:0] IV0  = 32'h1234_5678;
  localparam logic [31:0] IV1  = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        init_req = 1'b0;
  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = '0, web = '0;
  logic [7:0]  addra = '0, addrb = '0;
  logic [31:0] dina = '0, dinb = '0;

  logic        busy0, valida0, validb0, busy1, valida1, validb1;
  logic [31:0] douta0, doutb0, douta1, doutb1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ram_dp_be #(.WIDTH(32), .DEPTH(DEP0), .LG_DEPTH(8), .INIT_VAL(IV0),
              .RDW_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy0),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .valida(valida0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .validb(validb0));

  ram_dp_be #(.WIDTH(32), .DEPTH(DEP1), .LG_DEPTH(8), .INIT_VAL(IV1),
              .RDW_MODE(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy1),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .valida(valida1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .validb(validb1));

  // ---------------- model ----------------
  logic [31:0] mm [2][256];
  int          left_m [2];
  logic        ev_a [2], ev_b [2], pv_a [2], pv_b [2];
  logic [31:0] ed_a [2], ed_b [2], pd_a [2], pd_b [2];

  function automatic int dep(input int k);
    return (k == 0) ? DEP0 : DEP1;
  endfunction

  function automatic logic [31:0] iv(input int k);
    return (k == 0) ? IV0 : IV1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step(input int k);
    logic        bz, rqa, rqb, ina, inb;
    logic [31:0] olda, oldb, rda, rdb;
    bz   = (left_m[k] > 0);
    rqa  = ena && !bz;
    rqb  = enb && !bz;
    ina  = (int'(addra) < dep(k));
    inb  = (int'(addrb) < dep(k));
    olda = ina ? mm[k][addra] : 32'h0;
    oldb = inb ? mm[k][addrb] : 32'h0;
    if (bz) begin
      mm[k][dep(k) - left_m[k]] = iv(k);
      left_m[k]--;
    end else begin
      if (rqb && inb)
        for (int i = 0; i < 4; i++) if (web[i]) mm[k][addrb][8*i +: 8] = dinb[8*i +: 8];
      if (rqa && ina)
        for (int i = 0; i < 4; i++) if (wea[i]) mm[k][addra][8*i +: 8] = dina[8*i +: 8];
      if (init_req) left_m[k] = dep(k);
    end
    rda = (k == 1 && rqa && ina && wea != 4'h0) ? mm[k][addra] : olda;
    rdb = (k == 1 && rqb && inb && web != 4'h0) ? mm[k][addrb] : oldb;
    if (k == 0) begin
      ev_a[k] = rqa; if (rqa) ed_a[k] = rda;
      ev_b[k] = rqb; if (rqb) ed_b[k] = rdb;
    end else begin
      ev_a[k] = pv_a[k]; if (pv_a[k]) ed_a[k] = pd_a[k];
      ev_b[k] = pv_b[k]; if (pv_b[k]) ed_b[k] = pd_b[k];
      pv_a[k] = rqa; pd_a[k] = rda;
      pv_b[k] = rqb; pd_b[k] = rdb;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        left_m[k] = dep(k);
        ev_a[k] = 1'b0; ev_b[k] = 1'b0; pv_a[k] = 1'b0; pv_b[k] = 1'b0;
        ed_a[k] = '0;   ed_b[k] = '0;   pd_a[k] = '0;   pd_b[k] = '0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
    #1;
    chk("busy_u0",   32'(busy0),   32'(left_m[0] > 0));
    chk("valida_u0", 32'(valida0), 32'(ev_a[0]));
    chk("validb_u0", 32'(validb0), 32'(ev_b[0]));
    chk("douta_u0",  douta0,       ed_a[0]);
    chk("doutb_u0",  doutb0,       ed_b[0]);
    chk("busy_u1",   32'(busy1),   32'(left_m[1] > 0));
    chk("valida_u1", 32'(valida1), 32'(ev_a[1]));
    chk("validb_u1", 32'(validb1), 32'(ev_b[1]));
    chk("douta_u1",  douta1,       ed_a[1]);
    chk("doutb_u1",  doutb1,       ed_b[1]);
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_in();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0; init_req = 1'b0;
  endtask

  task automatic wr_a(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    ena = 1'b1; wea = be; addra = a; dina = d;
    @(negedge clk);
    idle_in();
  endtask

  task automatic rd_expect(input bit pb, input logic [7:0] a,
                           input logic [31:0] e0, input logic [31:0] e1, input string nm);
    if (pb) begin enb = 1'b1; web = '0; addrb = a; end
    else    begin ena = 1'b1; wea = '0; addra = a; end
    @(negedge clk);
    idle_in();
    chk({nm, "_u0"},   pb ? doutb0 : douta0, e0);
    chk({nm, "_v_u0"}, 32'(pb ? validb0 : valida0), 32'd1);
    @(negedge clk);
    chk({nm, "_u1"},   pb ? doutb1 : douta1, e1);
    chk({nm, "_v_u1"}, 32'(pb ? validb1 : valida1), 32'd1);
  endtask

  task automatic wait_idle(output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (!busy0 && !busy1) break;
      @(negedge clk);
    end
  endtask

  logic [7:0]  p_adr [3];
  logic [31:0] p_dat [3];

  initial begin
    int c0, c1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_idle(c0, c1);
    chk("busy_len_rst_u0", 32'(c0), 32'd256);
    chk("busy_len_rst_u1", 32'(c1), 32'd200);

    rd_expect(0, 8'd0,   IV0, IV1,   "init_rd0");
    rd_expect(0, 8'd128, IV0, IV1,   "init_rd128");
    rd_expect(0, 8'd255, IV0, 32'h0, "init_rd255");

    wr_a(8'd7, 32'h0, 4'hF);
    wr_a(8'd9, 32'h0, 4'hF);

    wr_a(8'd5, 32'hAABB_CCDD, 4'b1111);
    wr_a(8'd5, 32'h1122_3344, 4'b0101);
    chk("model_bytewr", mm[0][5], 32'hAA22_CC44);
    rd_expect(1, 8'd5, 32'hAA22_CC44, 32'hAA22_CC44, "bytewr");

    ena = 1'b1; wea = 4'hF; addra = 8'd7; dina = 32'hDEAD_BEEF;
    enb = 1'b1; web = 4'h0; addrb = 8'd7;
    @(negedge clk);
    idle_in();
    chk("rdw_a_u0", douta0, 32'h0);
    chk("rdw_b_u0", doutb0, 32'h0);
    @(negedge clk);
    chk("rdw_a_u1", douta1, 32'hDEAD_BEEF);
    chk("rdw_b_u1", doutb1, 32'h0);

    ena = 1'b1; wea = 4'b0011; addra = 8'd9; dina = 32'h1111_1111;
    enb = 1'b1; web = 4'b0110; addrb = 8'd9; dinb = 32'h2222_2222;
    @(negedge clk);
    idle_in();
    chk("col_a_u0", douta0, 32'h0);
    chk("col_b_u0", doutb0, 32'h0);
    @(negedge clk);
    chk("col_a_u1", douta1, 32'h0022_1111);
    chk("col_b_u1", doutb1, 32'h0022_1111);
    chk("model_col", mm[1][9], 32'h0022_1111);
    rd_expect(0, 8'd9, 32'h0022_1111, 32'h0022_1111, "col_rd");

    wr_a(8'd210, 32'h600D_F00D, 4'hF);
    rd_expect(0, 8'd210, 32'h600D_F00D, 32'h0, "oor");

    p_adr[0] = 8'd5; p_dat[0] = 32'hAA22_CC44;
    p_adr[1] = 8'd7; p_dat[1] = 32'hDEAD_BEEF;
    p_adr[2] = 8'd9; p_dat[2] = 32'h0022_1111;
    for (int j = 0; j < 5; j++) begin
      if (j < 3) begin ena = 1'b1; wea = '0; addra = p_adr[j]; end
      else idle_in();
      @(negedge clk);
      chk("pipe_v_u0", 32'(valida0), 32'(j < 3));
      if (j < 3) chk("pipe_d_u0", douta0, p_dat[j]);
      chk("pipe_v_u1", 32'(valida1), 32'(j >= 1 && j <= 3));
      if (j >= 1 && j <= 3) chk("pipe_d_u1", douta1, p_dat[j-1]);
    end
    idle_in();

    wr_a(8'd3, 32'hCAFE_F00D, 4'hF);
    rd_expect(0, 8'd3, 32'hCAFE_F00D, 32'hCAFE_F00D, "pre_init");
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (!busy0 && !busy1) break;
      init_req = (i == 20);
      if (i == 150) begin ena = 1'b1; wea = 4'hF; addra = 8'd3; dina = 32'hFFFF_FFFF; end
      else begin ena = 1'b0; wea = '0; end
      @(negedge clk);
    end
    idle_in();
    chk("busy_len_req_u0", 32'(c0), 32'd256);
    chk("busy_len_req_u1", 32'(c1), 32'd200);
    rd_expect(0, 8'd3, IV0, IV1, "post_init");

    wr_a(8'd150, 32'h0BAD_BEEF, 4'hF);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(c0, c1);
    chk("busy_len_mid_u0", 32'(c0), 32'd256);
    chk("busy_len_mid_u1", 32'(c1), 32'd200);
    rd_expect(0, 8'd150, IV0, IV1, "midrst");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
